sonic_upstream_gearbox: RTL

- Receive-side 40→64 gearbox: packs the PMA's 40-bit-per-cycle receive stream into 64-bit words.
- Writes each completed word into the RX buffer RAM using a one-cycle write strobe.
- Mirror of the downstream 64→40 gearbox, with the same LSB-first bit order: the first received bit becomes bit 0 of the first output word.
- Emits exactly 5 words per 8 input cycles on a fixed phase schedule.

---
 rtl/sonic_gearbox_pkg.sv | 15 +
 rtl/sonic_upstream_gearbox.sv | 80 ++++++++
 2 files changed

// File: rtl/sonic_gearbox_pkg.sv
// sonic_gearbox_pkg: shared widths, phase type and per-phase tables for the 40<->64 gearboxes
package sonic_gearbox_pkg;
    localparam int GB_PMA_W  = 40;
    localparam int GB_WORD_W = 64;
    localparam int GB_BUF_W  = 56;
    typedef logic [2:0] gb_phase_t;
    typedef enum logic {GB_IDLE = 1'b0, GB_RUN = 1'b1} gb_state_e;
    // bit p set when the capture in phase p completes a 64-bit word
    localparam logic [7:0] GB_WR_MASK = 8'b11011010;
    // residue fill level before a capture, indexed by phase
    localparam logic [7:0][5:0] GB_FILL = {6'd24, 6'd48, 6'd8, 6'd32, 6'd56, 6'd16, 6'd40, 6'd0};
    function automatic logic [5:0] gb_fill(input gb_phase_t p);
        return GB_FILL[p];
    endfunction
endpackage

// File: rtl/sonic_upstream_gearbox.sv
// sonic_upstream_gearbox: packs the 40-bit PMA receive stream LSB-first into 64-bit RAM words
module sonic_upstream_gearbox
    import sonic_gearbox_pkg::*;
#(
    parameter int INPUT_WIDTH  = GB_PMA_W,
    parameter int OUTPUT_WIDTH = GB_WORD_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ena,
    input  logic [INPUT_WIDTH-1:0]  data_in,
    output logic                    wrreq,
    output logic [OUTPUT_WIDTH-1:0] data_out,
    output logic [2:0]              phase
);
    gb_state_e              state_q, state_d;
    gb_phase_t              p_q, p_d, cur;
    logic [GB_BUF_W-1:0]    buf_q, buf_d, nbuf;
    logic [GB_WORD_W-1:0]   data_out_q, data_out_d, word;
    logic                   wr_q, wr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= GB_IDLE;
            p_q        <= '0;
            buf_q      <= '0;
            data_out_q <= '0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            buf_q      <= buf_d;
            data_out_q <= data_out_d;
            wr_q       <= wr_d;
        end
    end

    // Unused residue bits are forced to zero so the buffer content is reproducible.
    always_comb begin
        cur  = (state_q == GB_IDLE) ? 3'd0 : p_q;
        word = data_out_q;
        nbuf = '0;
        case (cur)
            3'd0: nbuf = {16'b0, data_in};
            3'd1: begin
                word = {data_in[23:0], buf_q[39:0]};
                nbuf = {40'b0, data_in[39:24]};
            end
            3'd2: nbuf = {data_in, buf_q[15:0]};
            3'd3: begin
                word = {data_in[7:0], buf_q[55:0]};
                nbuf = {24'b0, data_in[39:8]};
            end
            3'd4: begin
                word = {data_in[31:0], buf_q[31:0]};
                nbuf = {48'b0, data_in[39:32]};
            end
            3'd5: nbuf = {8'b0, data_in, buf_q[7:0]};
            3'd6: begin
                word = {data_in[15:0], buf_q[47:0]};
                nbuf = {32'b0, data_in[39:16]};
            end
            3'd7: begin
                word = {data_in, buf_q[23:0]};
                nbuf = '0;
            end
        endcase
        state_d    = ena ? GB_RUN : GB_IDLE;
        p_d        = ena ? cur + 3'd1 : 3'd0;
        buf_d      = ena ? nbuf : '0;
        wr_d       = ena & GB_WR_MASK[cur];
        data_out_d = wr_d ? word : data_out_q;
    end

    always_comb begin
        wrreq    = wr_q;
        data_out = data_out_q;
        phase    = p_q;
    end
endmodule
